// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared types for the chunked sequential adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

`default_nettype wire

// File: rtl/adder_chunked_seq_if.sv
// ============================================================================
// Module   : adder_chunked_seq_if
// Purpose  : Operand/result handshake bundle for adder_chunked_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adder_chunked_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, mode, signed_mode, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, mode, signed_mode, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

`default_nettype wire

// File: rtl/adder_cin_cout.sv
// ============================================================================
// Module   : adder_cin_cout
// Purpose  : Combinational WIDTH-bit adder with carry in and carry out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_cin_cout #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

`default_nettype wire

// File: rtl/adder_chunked_seq.sv
// ============================================================================
// Module   : adder_chunked_seq
// Purpose  : Multi-cycle add/subtract, one CHUNK-bit slice per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_chunked_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    adder_chunked_seq_if.slave     bus
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int MSB        = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("adder_chunked_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_mod_r;
    op_t              mode_r;
    logic             signed_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r, overflow_r, zero_r;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             carry_out;
    logic [WIDTH-1:0] result_full;
    logic             last_chunk, cout_final, signed_ovf;

    assign a_chunk    = a_r[idx*CHUNK +: CHUNK];
    assign b_chunk    = b_mod_r[idx*CHUNK +: CHUNK];
    assign last_chunk = (idx == LAST_IDX);

    adder_cin_cout #(.WIDTH(CHUNK)) u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (sum_chunk),
        .cout (carry_out)
    );

    // Final-chunk flags need the result including the slice being written now.
    always_comb begin
        result_full = result_r;
        result_full[idx*CHUNK +: CHUNK] = sum_chunk;
    end

    assign cout_final = (mode_r == OP_SUB) ? ~carry_out : carry_out;
    assign signed_ovf = (a_r[MSB] == b_mod_r[MSB]) && (result_full[MSB] != a_r[MSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) state_next = RUN;
                RUN:     if (last_chunk)   state_next = DONE;
                DONE:    if (bus.out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            carry      <= 1'b0;
            a_r        <= '0;
            b_mod_r    <= '0;
            mode_r     <= OP_ADD;
            signed_r   <= 1'b0;
            result_r   <= '0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (flush) begin
            idx   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r      <= bus.a;
                        b_mod_r  <= bus.mode ? ~bus.b : bus.b;
                        carry    <= bus.mode ^ bus.cin;
                        mode_r   <= op_t'(bus.mode);
                        signed_r <= bus.signed_mode;
                        idx      <= '0;
                    end
                end
                RUN: begin
                    result_r[idx*CHUNK +: CHUNK] <= sum_chunk;
                    carry <= carry_out;
                    if (last_chunk) begin
                        idx        <= '0;
                        cout_r     <= cout_final;
                        overflow_r <= signed_r ? signed_ovf : cout_final;
                        zero_r     <= (result_full == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;
endmodule

`default_nettype wire

// File: tb/tb_adder_chunked_seq.sv
// ============================================================================
// Module   : tb_adder_chunked_seq
// Purpose  : Self-checking bench with an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_chunked_seq;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NUM_CHUNKS = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    adder_chunked_seq_if #(.WIDTH(WIDTH)) bus ();

    adder_chunked_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic mode, input logic sm,
                         output logic [31:0] r, output logic co, output logic ov, output logic z);
        logic [32:0] t;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!mode) begin
            t  = {1'b0, a} + {1'b0, b} + 33'(cin);
            sr = sa + sb + longint'(cin);
        end else begin
            t  = {1'b0, a} - {1'b0, b} - 33'(cin);
            sr = sa - sb - longint'(cin);
        end
        r  = t[31:0];
        co = t[32];
        ov = sm ? ((sr > 64'sd2147483647) || (sr < -64'sd2147483648)) : co;
        z  = (r == 32'd0);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic mode, input logic sm);
        @(negedge clk);
        check("accept_ready", bus.in_ready, 1'b1);
        bus.a = a; bus.b = b; bus.cin = cin; bus.mode = mode; bus.signed_mode = sm;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic mode, input logic sm);
        logic [31:0] r; logic co, ov, z;
        model(a, b, cin, mode, sm, r, co, ov, z);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_result"}, bus.result, r);
        check({tag, "_cout"}, bus.cout, co);
        check({tag, "_ovf"}, bus.overflow, ov);
        check({tag, "_zero"}, bus.zero, z);
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, bus.out_valid, 1'b0);
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic mode, input logic sm);
        int cyc;
        start_op(a, b, cin, mode, sm);
        wait_valid(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(NUM_CHUNKS));
        check_out(tag, a, b, cin, mode, sm);
        finish_op(tag);
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb, held;
        logic rc, rm, rs;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.mode = 0;
        bus.signed_mode = 0; bus.out_ready = 0;

        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", {bus.cout, bus.overflow, bus.zero}, 3'b000);
        @(negedge clk); rst_n = 1'b1;

        full_op("uadd_carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        full_op("sadd_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        full_op("usub", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        full_op("ssub", 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
        full_op("usub_cin", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        full_op("sadd_cin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure in DONE while new operands are offered.
        start_op(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        check("bp_latency", 64'(cyc), 64'(NUM_CHUNKS));
        held = bus.result;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_hold", bus.result, held);
        end
        bus.in_valid = 1'b0;
        check_out("bp", 32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0, 1'b0);
        finish_op("bp");
        full_op("bp_next", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset at chunk index 2.
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_result", bus.result, 32'd0);
        check("arst_flags", {bus.cout, bus.overflow, bus.zero}, 3'b000);
        @(negedge clk); rst_n = 1'b1;
        full_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        check("post_rst_const", bus.result, 32'h2345_6789);

        // Flush during RUN at index 1.
        start_op(32'h0F0F_0F0F, 32'h1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_run_idle", bus.in_ready, 1'b1);
        check("flush_run_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < NUM_CHUNKS + 2; i++) begin
            @(posedge clk); #1;
            check("flush_run_stale", bus.out_valid, 1'b0);
        end
        full_op("post_flush_run", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1);

        // Flush in DONE together with out_ready, then flush against an input handshake.
        start_op(32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        @(negedge clk); flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        check("flush_done_valid", bus.out_valid, 1'b0);
        check("flush_done_idle", bus.in_ready, 1'b1);
        @(negedge clk); bus.in_valid = 1'b1;
        @(posedge clk); #1; flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_beats_accept", bus.in_ready, 1'b1);
        full_op("post_flush_done", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Randomized ops with random consumer stall.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rb = $urandom;
            if (n % 8 == 0) rb = ra;
            rc = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            start_op(ra, rb, rc, rm, rs);
            wait_valid(cyc);
            check("rnd_latency", 64'(cyc), 64'(NUM_CHUNKS));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check_out("rnd", ra, rb, rc, rm, rs);
            finish_op("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
